// File: rtl/spi_mux_guarded_if.sv
// Master-side SPI bus of spi_mux_guarded (csb/sclk/mosi toward the mux, miso back).
// Optional feature macro of the mux: SPI_MUX_MISO_SYNC_EN.
interface spi_mux_guarded_if;
    logic csb;
    logic sclk;
    logic mosi;
    logic miso;

    modport master (output csb, output sclk, output mosi, input miso);
    modport slave  (input csb, input sclk, input mosi, output miso);
endinterface

// File: rtl/spi_mux_guarded.sv
// SPI slave multiplexer with break-before-make guard, idle-deferred switching and override channel.
// Optional: define SPI_MUX_MISO_SYNC_EN to put a two-flop synchronizer in front of the miso register.
module spi_mux_guarded #(
    parameter int unsigned N_SLV     = 4,
    parameter int unsigned ADR_W     = 2,
    parameter int unsigned CPOL      = 0,
    parameter int unsigned GUARD_CYC = 4,
    parameter int unsigned OVR_CH    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADR_W-1:0]   slv_adr,
    spi_mux_guarded_if.slave   m,
    output logic [N_SLV-1:0]   s_csb,
    output logic [N_SLV-1:0]   s_sclk,
    output logic [N_SLV-1:0]   s_mosi,
    input  logic [N_SLV-1:0]   s_miso,
    input  logic               i_hold,
    input  logic               i_csb,
    input  logic               i_sclk,
    input  logic               i_mosi,
    output logic               busy,
    output logic [ADR_W-1:0]   sel,
    output logic               err
);

    localparam int unsigned GuardEff = (GUARD_CYC < 1) ? 1 : GUARD_CYC;
    localparam int unsigned CntW     = (GuardEff > 1) ? $clog2(GuardEff) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(GuardEff - 1);
    localparam logic CpolBit = (CPOL != 0);

    typedef enum logic [1:0] {StIdle, StGuard, StConn} state_e;

    state_e            state_q, state_d;
    logic [ADR_W-1:0]  tgt_q, tgt_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              miso_q;
    logic [N_SLV-1:0]  csb_q, sclk_q, mosi_q;
    logic [N_SLV-1:0]  csb_d, sclk_d, mosi_d;
    logic              adr_ok, fwd, miso_src;

    assign adr_ok = (32'(slv_adr) < N_SLV);

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (!m.csb || !adr_ok) begin
                    err_d = 1'b1;
                end else begin
                    tgt_d   = slv_adr;
                    cnt_d   = CntInit;
                    state_d = StGuard;
                end
            end
            StGuard: begin
                // A master starting a transfer mid-guard aborts the switch entirely.
                if (!m.csb || !adr_ok) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (slv_adr != tgt_q) begin
                    tgt_d = slv_adr;
                    cnt_d = CntInit;
                end else if (cnt_q == '0) begin
                    state_d = StConn;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StConn: begin
                if (slv_adr != tgt_q && m.csb) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Channels go idle on the same edge the FSM leaves CONN.
    assign fwd = (state_q == StConn) && (state_d == StConn);

    always_comb begin
        csb_d    = '1;
        sclk_d   = {N_SLV{CpolBit}};
        mosi_d   = '0;
        miso_src = 1'b0;
        for (int i = 0; i < int'(N_SLV); i++) begin
            if (tgt_q == ADR_W'(i)) begin
                miso_src = s_miso[i];
                if (fwd) begin
                    csb_d[i]  = m.csb;
                    sclk_d[i] = m.sclk;
                    mosi_d[i] = m.mosi;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            tgt_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            csb_q   <= '1;
            sclk_q  <= {N_SLV{CpolBit}};
            mosi_q  <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            csb_q   <= csb_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

`ifdef SPI_MUX_MISO_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            miso_q <= 1'b0;
        end else if (state_q == StConn) begin
            sync_q <= {sync_q[0], miso_src};
            miso_q <= sync_q[1];
        end else begin
            sync_q <= '0;
            miso_q <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_q <= 1'b0;
        end else begin
            miso_q <= (state_q == StConn) ? miso_src : 1'b0;
        end
    end
`endif

    // Initializer override bypasses the registers so it works even while rst is held.
    always_comb begin
        s_csb  = csb_q;
        s_sclk = sclk_q;
        s_mosi = mosi_q;
        if (i_hold) begin
            s_csb[OVR_CH]  = i_csb;
            s_sclk[OVR_CH] = i_sclk;
            s_mosi[OVR_CH] = i_mosi;
        end
    end

    assign m.miso = miso_q;
    assign busy   = (state_q != StConn);
    assign sel    = tgt_q;
    assign err    = err_q;

endmodule

// File: doc/spi_mux_guarded.md
Name: spi_mux_guarded

Overview:
Parametrised successor to the board SPI slave multiplexer. Routes one SPI master (csb/sclk/mosi/miso) to one of N_SLV slaves selected by slv_adr. Adds a break-before-make guard interval between slave switches, deferral of address changes until the master bus is idle, a busy/error status and a per-design idle clock polarity. Sits between the RTMQ SPI master and the on-board LMK/ROM/attenuator slaves; one channel can be overridden by a hardware initializer.

Parameters:
N_SLV, 4, number of slave channels (2..16)
ADR_W, 2, width of slv_adr; must satisfy 2**ADR_W >= N_SLV
CPOL, 0, idle level driven on s_sclk of unselected/idle channels
GUARD_CYC, 4, clk cycles all channels are held idle before a new slave is connected (values < 1 treated as 1)
OVR_CH, 0, channel index that i_hold overrides

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
slv_adr  in  ADR_W  requested slave index
csb  in  1  master chip select, active low
sclk  in  1  master serial clock
mosi  in  1  master data out
miso  out  1  registered data to master
s_csb  out  N_SLV  per-slave chip select
s_sclk  out  N_SLV  per-slave clock
s_mosi  out  N_SLV  per-slave data out
s_miso  in  N_SLV  per-slave data in
i_hold  in  1  initializer owns channel OVR_CH
i_csb, i_sclk, i_mosi  in  1 each  initializer bus
busy  out  1  high while no slave is connected (IDLE/GUARD)
sel  out  ADR_W  currently connected slave index (valid when busy=0)
err  out  1  sticky protocol error flag

Behaviour:
- Idle pattern per channel: s_csb=1, s_sclk=CPOL, s_mosi=0.
- Reset (async, any time, incl. mid-transfer): state=IDLE, all channels idle pattern, miso=0, busy=1, sel=0, err=0, guard counter=0.
- FSM states IDLE, GUARD, CONN; all outputs except the override path are registered.
- IDLE: if csb=1 and slv_adr<N_SLV: tgt<=slv_adr, cnt<=GUARD_CYC-1, go GUARD. If slv_adr>=N_SLV: stay IDLE, set err.
- GUARD: all channels idle. cnt decrements each cycle; at cnt=0 go CONN next cycle (GUARD_CYC=4 -> exactly 4 cycles in GUARD). If slv_adr changes while csb=1: reload tgt/cnt, remain GUARD (restart). Out-of-range address -> IDLE, err set.
- CONN: channel tgt gets {mosi,sclk,csb} registered (1-cycle latency); others idle. busy=0, sel=tgt.
- CONN, slv_adr!=tgt: if csb=1 -> IDLE (one idle cycle, then GUARD); if csb=0 -> change ignored, stay CONN until csb returns high (no switching mid-transaction).
- csb=0 seen while state is IDLE or GUARD -> err set; master bus not forwarded to any slave.
- miso: in CONN, miso<=s_miso[tgt] each cycle (1-cycle latency); otherwise miso<=0.
- i_hold=1: s_csb/s_sclk/s_mosi[OVR_CH] driven combinationally from i_csb/i_sclk/i_mosi, overriding FSM; FSM and other channels unaffected. If tgt=OVR_CH in CONN, master still receives s_miso[OVR_CH]. On i_hold fall, channel returns to FSM-registered value next edge.
- err clears only on rst.

Optional Feature:
SPI_MUX_MISO_SYNC_EN: when defined, s_miso[tgt] passes through a two-flop synchronizer before the miso register (miso latency 3 cycles, sync flops reset to 0 and cleared on leaving CONN). When undefined, single register, latency 1.

Test Plan:
- Reset with CPOL=1, N_SLV=4 -> s_csb=4'b1111, s_sclk=4'b1111, s_mosi=0, busy=1, err=0.
- slv_adr=2, csb=1 after reset -> busy falls after 1+4 cycles, sel=2; csb=0,sclk=1,mosi=1 appears on channel 2 one cycle later, channels 0/1/3 stay idle.
- In CONN on slave 2 with csb=0, change slv_adr to 1 -> channel 2 stays connected; csb->1 -> 1 IDLE + 4 GUARD cycles with all idle, then channel 1 connected, sel=1.
- s_miso=4'b0100 with sel=2 -> miso=1 one cycle later (3 cycles with SPI_MUX_MISO_SYNC_EN).
- slv_adr=5 with N_SLV=4, or csb=0 during GUARD -> err=1 and stays 1 until rst; no channel leaves idle.
- i_hold=1, OVR_CH=0, FSM connected to slave 3 -> s_csb[0]=i_csb combinationally, channel 3 traffic unaffected; assert rst mid-transfer -> all channels idle immediately except override path.
